// File: rtl/conv_pe_ctrl.sv
// Tile sequencer for a 3x3 conv_pe engine: preloads and swaps filters per tile,
// sweeps the output frame row by row, then waits for the engine to drain.
module conv_pe_ctrl #(
    parameter int K         = 3,
    parameter int Tin       = 4,
    parameter int W_Tin     = 2,
    parameter int W_SIZE    = 10,
    parameter int W_CHANNEL = 10,
    parameter int W_FADDR   = 12,
    parameter int W_VCNT    = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [W_SIZE-1:0]    cfg_width,
    input  logic [W_SIZE-1:0]    cfg_height,
    input  logic [W_CHANNEL-1:0] cfg_n_tiles,
    output logic                 busy,
    output logic                 done,
    output logic                 ifm_rd_en,
    output logic [W_SIZE-1:0]    ifm_rd_row,
    output logic [W_SIZE-1:0]    ifm_rd_col,
    output logic                 filter_rd_en,
    output logic [W_FADDR-1:0]   filter_rd_addr,
    output logic                 c_ctrl_data_run,
    output logic                 c_top_cal_start,
    output logic                 c_is_first_row,
    output logic                 c_is_last_row,
    output logic                 c_is_first_col,
    output logic                 c_is_last_col,
    output logic                 load_filter,
    output logic [W_Tin-1:0]     load_idx,
    output logic                 change_filter,
    input  logic                 pe_vld,
    output logic [W_CHANNEL-1:0] tile_idx
);

    localparam int W_TGT = 2 * W_SIZE + W_CHANNEL;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADF = 3'd1,
        LWAIT = 3'd2,
        SWAP  = 3'd3,
        ROW   = 3'd4,
        GAP   = 3'd5,
        DRAIN = 3'd6,
        FIN   = 3'd7
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [W_Tin-1:0]     idx_r, idx_nxt_s;
    logic [W_SIZE-1:0]    col_r, col_nxt_s;
    logic [W_SIZE-1:0]    row_r, row_nxt_s;
    logic [W_CHANNEL-1:0] tile_r, tile_nxt_s;
    logic                 gap_r, gap_nxt_s;

    logic [W_SIZE-1:0]    width_r, height_r;
    logic [W_CHANNEL-1:0] ntiles_r;
    logic [W_TGT-1:0]     target_r;
    logic [W_VCNT-1:0]    vcnt_r, vcnt_nxt_s;
    logic                 drained_s;
    logic                 degen_s;
    logic [W_FADDR-1:0]   faddr_nxt_s;
    logic [4:0]           rd_flags_s;

    logic                 busy_r, done_r;
    logic                 ifm_rd_en_r, filter_rd_en_r;
    logic [W_SIZE-1:0]    ifm_rd_row_r, ifm_rd_col_r;
    logic [W_FADDR-1:0]   filter_rd_addr_r;
    logic                 load_filter_r, change_filter_r;
    logic [W_Tin-1:0]     load_idx_r;
    // {en, first_row, last_row, first_col, last_col} per read, aged K cycles to the cal slot
    logic [4:0]           pipe_r [K];

    assign degen_s     = (cfg_width < W_SIZE'(2)) || (cfg_height == W_SIZE'(0)) ||
                         (cfg_n_tiles == W_CHANNEL'(0));
    assign faddr_nxt_s = W_FADDR'(tile_nxt_s) * W_FADDR'(Tin) + W_FADDR'(idx_nxt_s);
    assign drained_s   = W_TGT'(vcnt_nxt_s) >= target_r;

    // Output-valid counter next value: cleared on start, saturating count while busy.
    always_comb begin
        vcnt_nxt_s = vcnt_r;
        if ((state_r == IDLE) && start) begin
            vcnt_nxt_s = {W_VCNT{1'b0}};
        end else if (busy_r && pe_vld && (vcnt_r != {W_VCNT{1'b1}})) begin
            vcnt_nxt_s = vcnt_r + W_VCNT'(1);
        end else begin
            vcnt_nxt_s = vcnt_r;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        tile_nxt_s  = tile_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    idx_nxt_s  = W_Tin'(0);
                    col_nxt_s  = W_SIZE'(0);
                    row_nxt_s  = W_SIZE'(0);
                    tile_nxt_s = W_CHANNEL'(0);
                    gap_nxt_s  = 1'b0;
                    // degenerate jobs park in DRAIN with a zero target for one cycle
                    state_nxt_s = degen_s ? DRAIN : LOADF;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOADF: begin
                if (idx_r == W_Tin'(Tin - 1)) begin
                    state_nxt_s = LWAIT;
                    idx_nxt_s   = W_Tin'(0);
                end else begin
                    idx_nxt_s = idx_r + W_Tin'(1);
                end
            end
            LWAIT: state_nxt_s = SWAP;
            SWAP: begin
                state_nxt_s = ROW;
                col_nxt_s   = W_SIZE'(0);
            end
            ROW: begin
                if (col_r == width_r - W_SIZE'(1)) begin
                    state_nxt_s = GAP;
                    col_nxt_s   = W_SIZE'(0);
                    gap_nxt_s   = 1'b0;
                end else begin
                    col_nxt_s = col_r + W_SIZE'(1);
                end
            end
            GAP: begin
                if (!gap_r) begin
                    gap_nxt_s = 1'b1;
                end else if (row_r < height_r - W_SIZE'(1)) begin
                    state_nxt_s = ROW;
                    row_nxt_s   = row_r + W_SIZE'(1);
                    col_nxt_s   = W_SIZE'(0);
                end else if (tile_r < ntiles_r - W_CHANNEL'(1)) begin
                    state_nxt_s = LOADF;
                    tile_nxt_s  = tile_r + W_CHANNEL'(1);
                    row_nxt_s   = W_SIZE'(0);
                    idx_nxt_s   = W_Tin'(0);
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DRAIN: state_nxt_s = drained_s ? FIN : DRAIN;
            FIN:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read-stage border flags, gated by the read strobe.
    always_comb begin
        rd_flags_s = 5'b0_0000;
        if (ifm_rd_en_r) begin
            rd_flags_s = {1'b1,
                          row_r == W_SIZE'(0),
                          row_r == height_r - W_SIZE'(1),
                          col_r == W_SIZE'(0),
                          col_r == width_r - W_SIZE'(1)};
        end else begin
            rd_flags_s = 5'b0_0000;
        end
    end

    // State, counters, latched job configuration and output-valid counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            idx_r    <= W_Tin'(0);
            col_r    <= W_SIZE'(0);
            row_r    <= W_SIZE'(0);
            tile_r   <= W_CHANNEL'(0);
            gap_r    <= 1'b0;
            width_r  <= W_SIZE'(0);
            height_r <= W_SIZE'(0);
            ntiles_r <= W_CHANNEL'(0);
            target_r <= W_TGT'(0);
            vcnt_r   <= W_VCNT'(0);
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            col_r   <= col_nxt_s;
            row_r   <= row_nxt_s;
            tile_r  <= tile_nxt_s;
            gap_r   <= gap_nxt_s;
            vcnt_r  <= vcnt_nxt_s;
            if ((state_r == IDLE) && start) begin
                width_r  <= cfg_width;
                height_r <= cfg_height;
                ntiles_r <= cfg_n_tiles;
                target_r <= degen_s ? W_TGT'(0) :
                            W_TGT'(cfg_width) * W_TGT'(cfg_height) * W_TGT'(cfg_n_tiles);
            end else begin
                target_r <= target_r;
            end
        end
    end

    // Registered strobes/addresses decoded from the next state, plus delay stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            ifm_rd_en_r      <= 1'b0;
            ifm_rd_row_r     <= W_SIZE'(0);
            ifm_rd_col_r     <= W_SIZE'(0);
            filter_rd_en_r   <= 1'b0;
            filter_rd_addr_r <= W_FADDR'(0);
            change_filter_r  <= 1'b0;
            load_filter_r    <= 1'b0;
            load_idx_r       <= W_Tin'(0);
            for (int i = 0; i < K; i++) begin
                pipe_r[i] <= 5'b0_0000;
            end
        end else begin
            busy_r           <= (state_nxt_s != IDLE) && (state_nxt_s != FIN);
            done_r           <= state_nxt_s == FIN;
            ifm_rd_en_r      <= state_nxt_s == ROW;
            ifm_rd_row_r     <= (state_nxt_s == ROW) ? row_nxt_s : W_SIZE'(0);
            ifm_rd_col_r     <= (state_nxt_s == ROW) ? col_nxt_s : W_SIZE'(0);
            filter_rd_en_r   <= state_nxt_s == LOADF;
            filter_rd_addr_r <= (state_nxt_s == LOADF) ? faddr_nxt_s : W_FADDR'(0);
            change_filter_r  <= state_nxt_s == SWAP;
            load_filter_r    <= filter_rd_en_r;
            load_idx_r       <= filter_rd_en_r ? idx_r : W_Tin'(0);
            pipe_r[0]        <= rd_flags_s;
            for (int i = 1; i < K; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign ifm_rd_en       = ifm_rd_en_r;
    assign ifm_rd_row      = ifm_rd_row_r;
    assign ifm_rd_col      = ifm_rd_col_r;
    assign filter_rd_en    = filter_rd_en_r;
    assign filter_rd_addr  = filter_rd_addr_r;
    assign change_filter   = change_filter_r;
    assign load_filter     = load_filter_r;
    assign load_idx        = load_idx_r;
    assign tile_idx        = tile_r;
    assign c_ctrl_data_run = pipe_r[0][4];
    assign c_top_cal_start = pipe_r[K-1][4];
    assign c_is_first_row  = pipe_r[K-1][3];
    assign c_is_last_row   = pipe_r[K-1][2];
    assign c_is_first_col  = pipe_r[K-1][1];
    assign c_is_last_col   = pipe_r[K-1][0];

endmodule

// File: doc/conv_pe_ctrl.md
Name: conv_pe_ctrl

Overview:
- Sequencer for one conv_pe tile engine (3x3, Tin x Tout).
- Per tile it preloads the filter shadow registers, swaps them in, then sweeps the output frame row by row.
- Drives the IFM buffer read port, the filter buffer read port and all conv_pe strobes (ctrl_data_run, cal_start, border flags, change_filter, load_filter, load_idx).
- Counts pe_vld to detect drain, then pulses done.

Parameters:
- K, 3, kernel size; fixed 3, the timing below assumes it.
- Tin, 4, input channels per tile; also the filter load count.
- W_Tin, 2, width of load_idx; equals clog2(Tin).
- W_SIZE, 10, width of frame width/height and row/col counters.
- W_CHANNEL, 10, width of the tile count.
- W_FADDR, 12, width of the filter buffer address.
- W_VCNT, 24, width of the output-valid counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin a job; sampled in IDLE only
- cfg_width  in  W_SIZE  frame width W
- cfg_height  in  W_SIZE  frame height H
- cfg_n_tiles  in  W_CHANNEL  number of tiles N
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at job end
- ifm_rd_en  out  1  IFM buffer read strobe; read latency is 1 cycle
- ifm_rd_row  out  W_SIZE  centre row of the K-row window being read
- ifm_rd_col  out  W_SIZE  column being read
- filter_rd_en  out  1  filter buffer read strobe; read latency is 1 cycle
- filter_rd_addr  out  W_FADDR  tile*Tin + idx
- c_ctrl_data_run  out  1  ifm_rd_en delayed by 1 cycle
- c_top_cal_start  out  1  compute strobe
- c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col  out  1 each  border flags, aligned with c_top_cal_start
- load_filter  out  1  filter_rd_en delayed by 1 cycle
- load_idx  out  W_Tin  idx delayed by 1 cycle
- change_filter  out  1  one-cycle shadow-to-active swap
- pe_vld  in  1  conv_pe o_vld
- tile_idx  out  W_CHANNEL  current tile

Behaviour:
- Reset is asynchronous: every output goes to 0 and the FSM goes to IDLE.
  - Assertion mid-job aborts the job immediately.
  - All delay stages and counters clear. No done pulse is produced.
- cfg_* is latched on start in IDLE. start is ignored while busy.
- Degenerate config: if W<2, H=0 or N=0, then busy=1 for one cycle, done pulses the next cycle, and no strobes are issued.
- FSM states: IDLE, LOADF, LWAIT, SWAP, ROW, GAP, DRAIN, FIN.
  - LOADF (Tin cycles): filter_rd_en=1, idx 0..Tin-1.
  - LWAIT (1 cycle): carries the last load_filter.
  - SWAP (1 cycle): change_filter=1.
  - ROW (W cycles): ifm_rd_en=1, col 0..W-1, row = row counter.
  - GAP (2 cycles): idle.
  - After GAP, the next state is ROW (row+1) if row<H-1; else LOADF (tile+1, row=0) if tile<N-1; else DRAIN.
  - DRAIN waits until vcnt == W*H*N, then FIN. FIN: done=1, back to IDLE.
- Compute timing: for a row whose first read is cycle t:
  - c_ctrl_data_run is high on t+1..t+W.
  - c_top_cal_start is high on t+3..t+W+2, i.e. output col c at cycle t+3+c.
  - The final cal cycle (t+W+2) falls in the first cycle of the following state. This is legal: ROW's first data_run arrives one cycle later, and LOADF only writes the shadow registers.
- Border flags during cal for col c:
  - first_col = (c==0), last_col = (c==W-1).
  - first_row = (row==0), last_row = (row==H-1).
  - When H==1, first_row and last_row are both 1. All flags are 0 when cal_start is 0.
- Row period is W+2 cycles. Tile period is Tin+2 + H*(W+2) cycles.
- vcnt: cleared on start, +1 per pe_vld cycle, saturates at all-ones. pe_vld outside busy is ignored.
- tile_idx updates on entry to LOADF.
- filter_rd_addr = tile_idx*Tin + idx, truncated to W_FADDR.

Test Plan:
- Reset mid-ROW (rstn low at cycle 10) -> all outputs 0 in the same cycle; after release, IDLE, busy=0, no done pulse.
- W=4, H=3, N=1, start; pe_vld is mirrored from cal_start delayed by 4 cycles -> checks:
  - load_filter on 4 cycles with idx 0,1,2,3, then change_filter once.
  - 3 rows each: ifm_rd_en 4 cycles, cal_start 4 cycles starting 3 cycles after the row's first read.
  - Flags: first_col on cal 0, last_col on cal 3.
  - done one cycle after the 12th pe_vld; total cal_start count = 12.
- W=2, H=1, N=2 -> first_row=last_row=1 on every cal; filter_rd_addr 0..3 then 4..7; tile_idx 0 then 1; 4 cal_start total.
- Degenerate configs W=1, H=0 and N=0 (one case each) -> done pulse 2 cycles after start; no rd_en/cal_start/load_filter.
- start held high during busy plus a second start pulse -> ignored; exactly one done pulse.
- pe_vld withheld after the last cal -> FSM stays in DRAIN with busy=1; releasing the final pe_vld produces done on the next cycle.
